ppi_lane_distributor: RTL and testbench

Parametrised PPI transmit front end: accepts a packet stream of up to NUM_LANES bytes per beat and drives the per-lane PPI data and lane-enable signals toward the D-PHY model. It generalises the fixed 4-lane PPI bundle to a configurable lane count. It adds a run-time active-lane count, staggered lane-enable sequencing with matching per-lane data skew, last-beat byte fill, and underrun signalling.

---
 rtl/ppi_pkg.sv | 11 +
 rtl/ppi_lane_distributor_if.sv | 11 +
 rtl/ppi_skew_line.sv | 26 ++
 rtl/ppi_lane_distributor.sv | 69 ++++++
 tb/tb_ppi_lane_distributor.sv | 144 ++++++++++++++
 5 files changed

// File: rtl/ppi_pkg.sv
// ppi_pkg: shared types, limits and lane-count clamp for the PPI lane distributor
package ppi_pkg;
  localparam int MAX_LANES = 4;
  localparam logic [7:0] FILL_DEFAULT = 8'h00;
  typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, DRAIN = 2'd2} state_e;
  function automatic logic [2:0] clamp_lanes(input logic [2:0] cnt, input int max_lanes);
    if (cnt == 3'd0) return 3'd1;
    if (int'(cnt) > max_lanes) return 3'(max_lanes);
    return cnt;
  endfunction
endpackage

// File: rtl/ppi_lane_distributor_if.sv
// ppi_lane_distributor_if: upstream beat stream plus run-time lane count
interface ppi_lane_distributor_if #(parameter int NUM_LANES = 4, parameter int DATA_W = 8);
  logic [2:0]                  lane_cnt;
  logic [NUM_LANES*DATA_W-1:0] s_data;
  logic                        s_valid;
  logic                        s_last;
  logic [2:0]                  s_keep;
  logic                        s_ready;
  modport master (output lane_cnt, s_data, s_valid, s_last, s_keep, input s_ready);
  modport slave  (input lane_cnt, s_data, s_valid, s_last, s_keep, output s_ready);
endinterface

// File: rtl/ppi_skew_line.sv
// ppi_skew_line: DEPTH-stage shift register with async active-low clear; DEPTH=0 passes through
module ppi_skew_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  if (DEPTH == 0) begin : g_pass
    logic unused_ok;
    assign unused_ok = clk ^ rst_n;
    assign q = d;
  end else begin : g_sr
    logic [DEPTH-1:0][WIDTH-1:0] sr_q, sr_d;
    always_comb begin
      sr_d[0] = d;
      for (int k = 1; k < DEPTH; k++) sr_d[k] = sr_q[k-1];
    end
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) sr_q <= '0;
      else sr_q <= sr_d;
    assign q = sr_q[DEPTH-1];
  end
endmodule

// File: rtl/ppi_lane_distributor.sv
// ppi_lane_distributor: spreads packet beats over N active PPI lanes with staggered
// lane enables, last-beat fill and underrun signalling.
module ppi_lane_distributor
  import ppi_pkg::*;
#(
  parameter int                NUM_LANES = 4,
  parameter int                DATA_W    = 8,
  parameter logic [DATA_W-1:0] FILL_BYTE = DATA_W'(FILL_DEFAULT)
) (
  input  logic                        ppi_clk,
  input  logic                        ppi_rst_n,
  ppi_lane_distributor_if.slave       s,
  output logic [NUM_LANES*DATA_W-1:0] ppi_data,
  output logic [NUM_LANES-1:0]        ppi_lane_en,
  output logic                        underrun,
  output logic                        busy
);
  state_e                             state_q, state_d;
  logic [2:0]                         n_q, n_d, cnt_q, cnt_d, n_eff;
  logic                               rdy_q, rdy_d, und_q, und_d, acc;
  logic [NUM_LANES-1:0][DATA_W-1:0]   dat_q, dat_d;
  logic [NUM_LANES-1:0]               en_q, en_d;
  assign s.s_ready = rdy_q;
  assign acc       = s.s_valid && rdy_q;
  // lane count is only live in IDLE; afterwards the latched value rules the packet
  assign n_eff     = state_q == IDLE ? clamp_lanes(s.lane_cnt, NUM_LANES < MAX_LANES ? NUM_LANES : MAX_LANES) : n_q;
  always_comb begin
    n_d     = n_eff;
    cnt_d   = state_q == DRAIN ? cnt_q - 3'd1 : n_eff - 3'd1;
    state_d = acc ? (s.s_last ? DRAIN : ACTIVE) : (state_q == DRAIN && cnt_q == 3'd0) ? IDLE : state_q;
    rdy_d   = state_d != DRAIN;
    und_d   = state_q == ACTIVE && !s.s_valid;
    for (int i = 0; i < NUM_LANES; i++) begin
      en_d[i]  = 3'(i) < n_eff && (acc || und_d);
      dat_d[i] = (3'(i) < n_eff && acc && !(s.s_last && 3'(i) >= s.s_keep)) ? s.s_data[i*DATA_W +: DATA_W] : FILL_BYTE;
    end
  end
  always_ff @(posedge ppi_clk or negedge ppi_rst_n)
    if (!ppi_rst_n) begin
      state_q <= IDLE;
      n_q     <= 3'd1;
      cnt_q   <= '0;
      rdy_q   <= 1'b0;
      und_q   <= 1'b0;
      dat_q   <= '0;
      en_q    <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
      rdy_q   <= rdy_d;
      und_q   <= und_d;
      dat_q   <= dat_d;
      en_q    <= en_d;
    end
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    logic [DATA_W:0] q;
    ppi_skew_line #(.DEPTH(i), .WIDTH(DATA_W + 1)) u_skew (
      .clk  (ppi_clk),
      .rst_n(ppi_rst_n),
      .d    ({en_q[i], dat_q[i]}),
      .q    (q)
    );
    assign ppi_lane_en[i]               = q[DATA_W];
    assign ppi_data[i*DATA_W +: DATA_W] = q[DATA_W-1:0];
  end
  assign underrun = und_q;
  assign busy     = state_q != IDLE || |ppi_lane_en;
endmodule

// File: tb/tb_ppi_lane_distributor.sv
// tb_ppi_lane_distributor: directed and random beats checked against a per-edge lane timeline model
module tb_ppi_lane_distributor;
  localparam int NL = 4;
  localparam int DW = 8;
  localparam logic [7:0] FILL = 8'h00;
  logic ppi_clk = 1'b0;
  logic ppi_rst_n = 1'b0;
  logic [NL*DW-1:0] ppi_data;
  logic [NL-1:0] ppi_lane_en;
  logic underrun, busy;
  ppi_lane_distributor_if #(.NUM_LANES(NL), .DATA_W(DW)) s_if ();
  ppi_lane_distributor #(.NUM_LANES(NL), .DATA_W(DW), .FILL_BYTE(FILL)) dut (
    .ppi_clk    (ppi_clk),
    .ppi_rst_n  (ppi_rst_n),
    .s          (s_if),
    .ppi_data   (ppi_data),
    .ppi_lane_en(ppi_lane_en),
    .underrun   (underrun),
    .busy       (busy)
  );
  always #5 ppi_clk = ~ppi_clk;
  int tests = 0, fails = 0;
  int e, ready_from, m_n, last_l, last_n;
  bit in_pkt;
  logic [NL-1:0]    h_en  [0:8191];
  logic [NL*DW-1:0] h_dat [0:8191];
  bit               h_und [0:8191];
  // a lane that is part of the packet must follow its neighbour's rising enable by one cycle
  for (genvar i = 1; i < NL; i++) begin : g_a
    assert property (@(posedge ppi_clk) disable iff (!ppi_rst_n)
      $rose(ppi_lane_en[i-1]) |=> ($rose(ppi_lane_en[i]) || i >= m_n))
    else $error("FAIL skew_rise lane %0d", i);
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, e);
    end
  endtask
  task automatic model_reset();
    e = 0; ready_from = 1; m_n = 1; in_pkt = 0; last_l = -100; last_n = 0;
  endtask
  function automatic int clampn(input int c);
    return c == 0 ? 1 : (c > NL ? NL : c);
  endfunction
  task automatic check_outputs();
    int p = e - 1;
    logic [NL-1:0] en_x = '0;
    logic [NL*DW-1:0] dat_x = '0;
    for (int i = 0; i < NL; i++)
      if (p - i >= 0) begin
        en_x[i] = h_en[p-i][i];
        dat_x[i*DW +: DW] = h_dat[p-i][i*DW +: DW];
      end
    chk("lane_en", ppi_lane_en, en_x);
    chk("data", ppi_data, dat_x);
    chk("underrun", underrun, p >= 0 ? h_und[p] : 1'b0);
    chk("busy", busy, in_pkt || (p >= last_l && p < last_l + last_n) || |en_x);
  endtask
  task automatic model_edge(input bit v, input bit last, input int keep, input int cnt, input logic [NL*DW-1:0] d);
    logic [NL-1:0] en = '0;
    logic [NL*DW-1:0] dd = {NL{FILL}};
    bit u = 0;
    if (v && e >= ready_from) begin
      if (!in_pkt) begin m_n = clampn(cnt); in_pkt = 1; end
      for (int i = 0; i < m_n; i++) begin
        en[i] = 1'b1;
        dd[i*DW +: DW] = (last && i >= keep) ? FILL : d[i*DW +: DW];
      end
      if (last) begin in_pkt = 0; last_l = e; last_n = m_n; ready_from = e + m_n + 1; end
    end else if (in_pkt) begin
      u = 1;
      for (int i = 0; i < m_n; i++) en[i] = 1'b1;
    end
    h_en[e] = en; h_dat[e] = dd; h_und[e] = u; e++;
  endtask
  // entered and left at a negedge; the DUT samples the driven beat at the posedge between
  task automatic step(input bit v, input bit last, input int keep, input int cnt, input logic [NL*DW-1:0] d);
    check_outputs();
    s_if.s_valid = v; s_if.s_last = last; s_if.s_keep = 3'(keep); s_if.lane_cnt = 3'(cnt); s_if.s_data = d;
    chk("s_ready", s_if.s_ready, e >= ready_from);
    @(posedge ppi_clk);
    model_edge(v, last, keep, cnt, d);
    @(negedge ppi_clk);
  endtask
  task automatic idle(input int k);
    for (int j = 0; j < k; j++) step(0, 0, 1, 4, '0);
  endtask
  task automatic rand_run(input int k);
    for (int j = 0; j < k; j++)
      step($urandom_range(0, 9) < 8, $urandom_range(0, 3) == 0, $urandom_range(1, 4), $urandom_range(0, 7), $urandom);
  endtask
  initial begin
    s_if.s_valid = 0; s_if.s_last = 0; s_if.s_keep = 3'd1; s_if.lane_cnt = 3'd4; s_if.s_data = '0;
    model_reset();
    repeat (3) @(negedge ppi_clk);
    chk("rst_ready", s_if.s_ready, 1'b0);
    chk("rst_en", ppi_lane_en, '0);
    chk("rst_data", ppi_data, '0);
    chk("rst_busy", busy, 1'b0);
    ppi_rst_n = 1'b1;
    idle(2);
    step(1, 0, 4, 4, 32'h03020100);
    step(1, 0, 4, 4, 32'h07060504);
    step(1, 1, 4, 4, 32'h0B0A0908);
    idle(6);
    step(1, 1, 1, 2, 32'h0000BBAA);
    idle(5);
    step(1, 0, 4, 4, $urandom);
    step(0, 0, 4, 4, $urandom);
    step(1, 1, 4, 4, $urandom);
    idle(6);
    for (int j = 0; j < 15; j++) step(1, j % 3 == 2, 3, 3, $urandom);
    idle(5);
    step(1, 0, 4, 0, $urandom);
    step(1, 1, 4, 0, $urandom);
    idle(3);
    step(1, 0, 2, 7, $urandom);
    step(1, 1, 2, 7, $urandom);
    idle(6);
    rand_run(1500);
    idle(6);
    step(1, 0, 4, 4, $urandom);
    step(1, 0, 4, 4, $urandom);
    ppi_rst_n = 1'b0;
    #1;
    chk("arst_en", ppi_lane_en, '0);
    chk("arst_data", ppi_data, '0);
    chk("arst_ready", s_if.s_ready, 1'b0);
    chk("arst_busy", busy, 1'b0);
    repeat (2) @(posedge ppi_clk);
    @(negedge ppi_clk);
    ppi_rst_n = 1'b1;
    model_reset();
    idle(1);
    step(1, 1, 3, 3, 32'h44332211);
    idle(5);
    rand_run(800);
    idle(6);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
